// File: rtl/covert_rep_encoder.sv
// covert_rep_encoder: encodes message bits as windows of packet field values.
// A '1' window repeats its first (anchor) value REP_COUNT times; a '0' window
// carries only fresh, distinct values drawn from a Galois LFSR.
module covert_rep_encoder #(
    parameter int unsigned           FIELD_SIZE  = 16,
    parameter int unsigned           WINDOW_SIZE = 32,
    parameter int unsigned           REP_COUNT   = 5,
    parameter logic [FIELD_SIZE-1:0] SEED        = 16'hACE1,
    parameter logic [FIELD_SIZE-1:0] TAPS        = 16'hB400
) (
    input  logic                  sys_clk,
    input  logic                  reset,
    input  logic                  bit_valid,
    input  logic                  bit_data,
    output logic                  bit_ready,
    input  logic                  pkt_req,
    output logic                  field_valid,
    output logic [FIELD_SIZE-1:0] field,
    output logic                  window_start,
    output logic                  busy
);

    localparam int unsigned SLOT_W = $clog2(WINDOW_SIZE);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(WINDOW_SIZE - 1);
    localparam logic [SLOT_W-1:0] REP_LAST  = SLOT_W'(REP_COUNT);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic                  cur_bit_q, cur_bit_d;
    logic [FIELD_SIZE-1:0] anchor_q, anchor_d;
    logic [FIELD_SIZE-1:0] lfsr_q, lfsr_d;
    logic [FIELD_SIZE-1:0] lfsr_adv;
    logic [FIELD_SIZE-1:0] field_d;
    logic                  field_valid_d;
    logic                  window_start_d;
    logic                  busy_d;

    // Next LFSR value, used only when a fresh value is emitted
    assign lfsr_adv = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);

    // Ready is a straight decode of the state, forced low while reset is applied
    assign bit_ready = (state_q == IDLE) && !reset;

    // State, counters, LFSR and registered outputs
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q      <= IDLE;
            slot_q       <= '0;
            cur_bit_q    <= 1'b0;
            anchor_q     <= '0;
            lfsr_q       <= SEED;
            field        <= '0;
            field_valid  <= 1'b0;
            window_start <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            cur_bit_q    <= cur_bit_d;
            anchor_q     <= anchor_d;
            lfsr_q       <= lfsr_d;
            field        <= field_d;
            field_valid  <= field_valid_d;
            window_start <= window_start_d;
            busy         <= busy_d;
        end
    end

    // Next-state, field selection and output decode
    always_comb begin
        state_d        = state_q;
        slot_d         = slot_q;
        cur_bit_d      = cur_bit_q;
        anchor_d       = anchor_q;
        lfsr_d         = lfsr_q;
        field_d        = field;
        field_valid_d  = 1'b0;
        window_start_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bit_valid) begin
                    cur_bit_d = bit_data;
                    slot_d    = '0;
                    state_d   = EMIT;
                end
            end
            EMIT: begin
                if (pkt_req) begin
                    field_valid_d = 1'b1;
                    slot_d        = slot_q + SLOT_W'(1);
                    if (slot_q == '0) begin
                        // Slot 0 fixes the anchor that a '1' window repeats
                        field_d        = lfsr_q;
                        anchor_d       = lfsr_q;
                        lfsr_d         = lfsr_adv;
                        window_start_d = 1'b1;
                    end else if (cur_bit_q && (slot_q <= REP_LAST)) begin
                        field_d = anchor_q;
                    end else begin
                        field_d = lfsr_q;
                        lfsr_d  = lfsr_adv;
                    end
                    if (slot_q == LAST_SLOT) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == EMIT);
    end

endmodule

// File: tb/tb_covert_rep_encoder.sv
// Testbench for covert_rep_encoder: table of windows plus hand-written
// reset/idle sequences; a scoreboard queue checks every emitted field.
module tb_covert_rep_encoder;

    localparam int unsigned WS   = 32;
    localparam int unsigned RC   = 5;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [15:0] TAPS = 16'hB400;

    logic        sys_clk = 1'b0;
    logic        reset = 1'b1;
    logic        bit_valid = 1'b0;
    logic        bit_data = 1'b0;
    logic        bit_ready;
    logic        pkt_req = 1'b0;
    logic        field_valid;
    logic [15:0] field;
    logic        window_start;
    logic        busy;

    always #5 sys_clk = ~sys_clk;

    covert_rep_encoder #(
        .FIELD_SIZE (16),
        .WINDOW_SIZE(WS),
        .REP_COUNT  (RC),
        .SEED       (SEED),
        .TAPS       (TAPS)
    ) dut (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .bit_valid   (bit_valid),
        .bit_data    (bit_data),
        .bit_ready   (bit_ready),
        .pkt_req     (pkt_req),
        .field_valid (field_valid),
        .field       (field),
        .window_start(window_start),
        .busy        (busy)
    );

    typedef struct {
        logic [15:0] val;
        logic        ws;
        int          cyc;
    } exp_t;

    typedef struct {
        bit          do_rst;
        int          pre_idle;
        logic        b;
        bit          gapped;
        int          exp_reps;
        int          chk_idx;
        logic [15:0] chk_val;
    } vec_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    vec_t        vecs[9];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] m_lfsr = SEED;
    logic [15:0] m_anchor = 16'h0;
    logic [15:0] last_field = 16'h0;
    logic [15:0] win_log[WS];
    int          win_wr = 0;
    bit          seen[logic [15:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] adv(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? TAPS : 16'h0);
    endfunction

    // Monitor: pop the scoreboard on each field pulse, check hold between pulses
    always @(posedge sys_clk) begin
        cyc++;
        #1;
        if (reset) begin
            last_field = field;
        end else if (field_valid) begin
            if (sbq.size() == 0) begin
                check("unexpected_field_valid", 32'(field_valid), 32'(0));
            end else begin
                mon_e = sbq.pop_front();
                check("field", 32'(field), 32'(mon_e.val));
                check("window_start", 32'(window_start), 32'(mon_e.ws));
                check("latency", 32'(cyc - 1), 32'(mon_e.cyc));
            end
            if (win_wr < WS) win_log[win_wr] = field;
            win_wr++;
            last_field = field;
        end else begin
            check("ws_without_valid", 32'(window_start), 32'(0));
            check("field_hold", 32'(field), 32'(last_field));
        end
    end

    // Assert reset for one cycle; must be called at a negedge
    task automatic do_reset();
        reset     = 1'b1;
        bit_valid = 1'b0;
        pkt_req   = 1'b1;
        #1 check("ready_in_reset", 32'(bit_ready), 32'(0));
        @(negedge sys_clk);
        check("rst_field_valid", 32'(field_valid), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_field", 32'(field), 32'(0));
        check("rst_window_start", 32'(window_start), 32'(0));
        reset   = 1'b0;
        pkt_req = 1'b0;
        m_lfsr   = SEED;
        m_anchor = 16'h0;
        sbq.delete();
        #1 check("ready_after_reset", 32'(bit_ready), 32'(1));
    endtask

    // Offer a bit, then request n_slots fields; must be called at a negedge
    task automatic send_window(input logic b, input bit gapped, input int n_slots);
        int          guard = 0;
        int          slot = 0;
        logic [15:0] ev;
        logic        ews;
        while (!bit_ready && guard < 20) begin
            @(negedge sys_clk);
            guard++;
        end
        check("ready_before_bit", 32'(bit_ready), 32'(1));
        bit_valid = 1'b1;
        bit_data  = b;
        pkt_req   = !gapped;
        win_wr    = 0;
        @(negedge sys_clk);
        bit_valid = 1'b0;
        bit_data  = ~b;
        check("busy_after_accept", 32'(busy), 32'(1));
        check("ready_low_in_emit", 32'(bit_ready), 32'(0));
        guard = 0;
        while (slot < n_slots && guard < 1000) begin
            pkt_req = gapped ? ($urandom_range(0, 2) == 0) : 1'b1;
            if (pkt_req) begin
                ews = (slot == 0);
                if (slot == 0) begin
                    ev       = m_lfsr;
                    m_anchor = m_lfsr;
                    m_lfsr   = adv(m_lfsr);
                end else if (b && slot <= RC) begin
                    ev = m_anchor;
                end else begin
                    ev     = m_lfsr;
                    m_lfsr = adv(m_lfsr);
                end
                sbq.push_back('{ev, ews, cyc});
                slot++;
            end
            @(negedge sys_clk);
            guard++;
        end
        pkt_req = 1'b0;
        check("window_timeout", 32'(slot), 32'(n_slots));
        if (n_slots == WS) check("ready_after_window", 32'(bit_ready), 32'(1));
    endtask

    // Count in-window repeats and cross-window reuse of fresh values
    task automatic analyse(input int exp_reps);
        int reps = 0;
        int dups = 0;
        bit hit;
        check("window_len", 32'(win_wr), 32'(WS));
        for (int i = 1; i < WS; i++) begin
            hit = 1'b0;
            for (int j = 0; j < i; j++) if (win_log[i] == win_log[j]) hit = 1'b1;
            if (hit) reps++;
        end
        check("repeats", 32'(reps), 32'(exp_reps));
        for (int i = 0; i < WS; i++) begin
            if (i == 0 || win_log[i] != win_log[0]) begin
                if (seen.exists(win_log[i])) dups++;
                seen[win_log[i]] = 1'b1;
            end
        end
        check("global_dups", 32'(dups), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 0, 1'b1, 1'b0, 5, 6, 16'hE270};
        vecs[1] = '{1'b1, 0, 1'b0, 1'b0, 0, 1, 16'hE270};
        vecs[2] = '{1'b1, 0, 1'b1, 1'b1, 5, 5, 16'hACE1};
        vecs[3] = '{1'b1, 6, 1'b0, 1'b0, 0, 1, 16'hE270};
        vecs[4] = '{1'b0, 0, 1'b1, 1'b0, 5, -1, 16'h0};
        vecs[5] = '{1'b0, 0, 1'b0, 1'b0, 0, -1, 16'h0};
        vecs[6] = '{1'b0, 0, 1'b1, 1'b0, 5, -1, 16'h0};
        vecs[7] = '{1'b0, 0, 1'b1, 1'b0, 5, -1, 16'h0};
        vecs[8] = '{1'b0, 0, 1'b0, 1'b0, 0, -1, 16'h0};

        @(negedge sys_clk);
        for (int r = 0; r < 9; r++) begin
            if (vecs[r].do_rst) begin
                do_reset();
                seen.delete();
            end
            for (int k = 0; k < vecs[r].pre_idle; k++) begin
                pkt_req   = 1'b1;
                bit_valid = 1'b0;
                bit_data  = k[0];
                @(negedge sys_clk);
            end
            pkt_req = 1'b0;
            if (vecs[r].pre_idle > 0) begin
                check("idle_busy", 32'(busy), 32'(0));
                check("idle_field_valid", 32'(field_valid), 32'(0));
            end
            send_window(vecs[r].b, vecs[r].gapped, WS);
            analyse(vecs[r].exp_reps);
            if (vecs[r].do_rst) check("first_field", 32'(win_log[0]), 32'(SEED));
            if (vecs[r].chk_idx >= 0)
                check("table_field", 32'(win_log[vecs[r].chk_idx]), 32'(vecs[r].chk_val));
        end

        // Reset in the middle of a '1' window abandons it
        do_reset();
        send_window(1'b1, 1'b0, 10);
        do_reset();
        repeat (2) @(negedge sys_clk);
        check("abandoned_no_field", 32'(field_valid), 32'(0));
        seen.delete();
        send_window(1'b1, 1'b0, WS);
        analyse(RC);
        check("restart_first_field", 32'(win_log[0]), 32'(SEED));
        check("restart_seventh_field", 32'(win_log[6]), 32'(16'hE270));

        repeat (3) @(negedge sys_clk);
        check("scoreboard_drained", 32'(sbq.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/covert_rep_encoder.md
# covert_rep_encoder

Transmit-side counterpart of the windowed repetition detector. It encodes a message bit stream into a stream of packet field values. Each message bit occupies one window of WINDOW_SIZE emitted fields:
- A '1' window contains REP_COUNT repeats of an earlier value in the same window.
- A '0' window contains only distinct values.

Fresh values come from a Galois LFSR. The block sits in the packet-generation path, ahead of the header writer. It is used for loopback testing of the detector and for characterising false-positive and false-negative rates.

## Interface
Parameters:
- FIELD_SIZE, 16, width of each emitted field value.
- WINDOW_SIZE, 32, fields per message bit. Must be a power of two, ≥ 2, and < 2^FIELD_SIZE − 1.
- REP_COUNT, 5, repeats per '1' window. Legal range 1..WINDOW_SIZE−1.
- SEED, 16'hACE1, LFSR reset value. Must be non-zero.
- TAPS, 16'hB400, Galois feedback mask, FIELD_SIZE bits wide.

Ports:
- sys_clk  in  1  the single clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- bit_valid  in  1  a message bit is offered.
- bit_data  in  1  value of the offered message bit.
- bit_ready  out  1  the block can accept a bit; equals (state == IDLE).
- pkt_req  in  1  a packet slot needs a field value this cycle.
- field_valid  out  1  field holds a new value; one-cycle pulse per request.
- field  out  FIELD_SIZE  the emitted field value.
- window_start  out  1  qualifies field_valid; marks slot 0 of a window.
- busy  out  1  high while in EMIT.

## Operation
States:
- IDLE:
  - bit_ready=1.
  - pkt_req is ignored: no field is emitted and no counter advances.
  - On bit_valid & bit_ready: latch bit_data into cur_bit, clear slot_cnt to 0, go to EMIT.
- EMIT:
  - bit_ready=0.
  - Each cycle with pkt_req, emit one field for slot slot_cnt.
  - slot_cnt is $clog2(WINDOW_SIZE) bits and increments once per emission.
  - After emitting slot WINDOW_SIZE−1, slot_cnt wraps to 0 and the state returns to IDLE.

Field selection for each emission:
- Slot 0: value = lfsr. Store it in the anchor register. Advance the LFSR. Assert window_start.
- Slots 1..REP_COUNT with cur_bit=1: value = anchor. The LFSR does not advance.
- All other slots, and every slot when cur_bit=0: value = lfsr. Advance the LFSR.

LFSR rules:
- Advance: lfsr ← (lfsr >> 1) ^ (lfsr[0] ? TAPS : 0).
- The LFSR advances only when a fresh value is emitted.
- It is not reset between windows.
- Fresh values within one window are therefore distinct, and never equal the anchor.
- A '1' window thus produces exactly REP_COUNT repeats. A '0' window produces zero repeats.

pkt_req outside EMIT has no effect. The consumer must keep its own packet count aligned to emitted fields only.

Reset (synchronous):
- Outputs: field_valid=0, field=0, window_start=0, busy=0. bit_ready is 0 during the reset cycle.
- State: state=IDLE, slot_cnt=0, anchor=0, cur_bit=0, lfsr=SEED.
- Reset asserted mid-window abandons the partial window. No further fields from that window are emitted.

## Timing
- Bit accepted at cycle t → busy=1 at t+1. The first pkt_req that counts is at t+1 or later.
- pkt_req at cycle t (in EMIT) → field_valid=1 and field valid at t+1. field holds its value until the next emission.
- Emission of slot WINDOW_SIZE−1 at cycle t:
  - state=IDLE and bit_ready=1 from t+1.
  - A bit offered at t+1 is accepted at t+1, giving EMIT at t+2.
  - pkt_req at t+1 is dropped.
- Back-to-back pkt_req every cycle sustains one field per cycle.
- bit_valid while bit_ready=0 is not accepted. The sender must hold the bit, standard valid/ready.
- reset has priority over every other input in the same cycle.

## Test plan
Common configuration: WINDOW_SIZE=32, REP_COUNT=5, SEED=16'hACE1, TAPS=16'hB400, unless stated otherwise.

1. Reset, send bit 1, pkt_req held high → expected response:
   - Fields 0xACE1 ×6 (slots 0–5), then 0xE270, then 25 further distinct LFSR values.
   - window_start high only on the first field.
   - bit_ready=1 the cycle after the 32nd field.
2. Reset, send bit 0 → expected response:
   - 32 fields, all distinct.
   - The first two fields are 0xACE1 and 0xE270.
   - No value repeats.
3. Gapped pkt_req (randomly one cycle in three) → expected response:
   - The field sequence is identical to scenario 1.
   - Each field_valid pulse occurs exactly one cycle after its pkt_req.
   - field is stable between pulses.
4. Loopback into the windowing detector (THRESHOLD=5), message 1,0,1,1,0 sent back-to-back with continuous pkt_req → expected response:
   - found is asserted within a few cycles after each '1' window closes.
   - found is low after each '0' window.
   - No LFSR value is emitted twice across the whole test.
5. pkt_req and bit_valid pulsed while IDLE with bit_valid low → expected response: no field_valid, and the LFSR is unchanged (next window starts at 0xACE1).
6. reset asserted at slot 10 of a '1' window → expected response:
   - The next cycle shows field_valid=0, busy=0, and bit_ready=1 after reset deasserts.
   - The next window starts again at 0xACE1.
